// File: rtl/spi_sdram_bridge.sv
// Decodes 16-bit SPI command words into register reads and SDRAM single/burst requests.
// Optional read-wait timeout is enabled by defining SPI_SDRAM_BRIDGE_TIMEOUT_EN.
module spi_sdram_bridge #(
    parameter int          WR_HOLD        = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] ID_WORD        = 16'h5555
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] word_i,
    input  logic        word_valid_i,
    output logic [15:0] word_o,
    output logic [31:0] wr_addr_o,
    output logic [15:0] wr_data_o,
    output logic        wr_enable_o,
    output logic [31:0] rd_addr_o,
    output logic        rd_enable_o,
    input  logic [15:0] rd_data_i,
    input  logic        rd_ready_i,
    input  logic        busy_i,
    output logic        ovf_o,
    output logic        tmo_o
);

`ifdef SPI_SDRAM_BRIDGE_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    localparam int HOLD_LAST = (WR_HOLD > 0) ? (WR_HOLD - 1) : 0;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REG_RD   = 4'd1;
    localparam logic [3:0] S_ADDR_LO  = 4'd2;
    localparam logic [3:0] S_ADDR_HI  = 4'd3;
    localparam logic [3:0] S_CNT      = 4'd4;
    localparam logic [3:0] S_DATA     = 4'd5;
    localparam logic [3:0] S_WR_ISSUE = 4'd6;
    localparam logic [3:0] S_WR_HOLD  = 4'd7;
    localparam logic [3:0] S_RD_ISSUE = 4'd8;
    localparam logic [3:0] S_RD_WAIT  = 4'd9;

    localparam logic [1:0] CMD_RD    = 2'd0;
    localparam logic [1:0] CMD_WR    = 2'd1;
    localparam logic [1:0] CMD_BURST = 2'd2;

    logic [3:0]  state_r, state_nxt_s;
    logic [1:0]  cmd_r;
    logic [31:0] mem_addr_r;
    logic [15:0] mem_dat_r;
    logic [7:0]  reg_addr_r;
    logic [15:0] cnt_r;
    logic [15:0] hold_cnt_r;
    logic [31:0] tmo_cnt_r;
    logic        ovf_r, tmo_r;
    logic        wr_enable_r, rd_enable_r;
    logic [31:0] wr_addr_r, rd_addr_r;
    logic [15:0] wr_data_r;

    logic        hold_done_s, timeout_s, wr_pulse_s, rd_pulse_s, drop_s, clr_flags_s;
    logic [15:0] word_s;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (word_valid_i) begin
                    case (word_i[15:8])
                        8'h80:                state_nxt_s = S_REG_RD;
                        8'hC0, 8'hC1, 8'hC2:  state_nxt_s = S_ADDR_LO;
                        default:              state_nxt_s = S_IDLE;
                    endcase
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REG_RD:  state_nxt_s = word_valid_i ? S_IDLE : S_REG_RD;
            S_ADDR_LO: state_nxt_s = word_valid_i ? S_ADDR_HI : S_ADDR_LO;
            S_ADDR_HI: begin
                if (!word_valid_i) begin
                    state_nxt_s = S_ADDR_HI;
                end else if (cmd_r == CMD_RD) begin
                    state_nxt_s = S_RD_ISSUE;
                end else if (cmd_r == CMD_BURST) begin
                    state_nxt_s = S_CNT;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_CNT: begin
                if (!word_valid_i) begin
                    state_nxt_s = S_CNT;
                end else if (word_i == 16'd0) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_DATA:     state_nxt_s = word_valid_i ? S_WR_ISSUE : S_DATA;
            S_WR_ISSUE: state_nxt_s = busy_i ? S_WR_ISSUE : S_WR_HOLD;
            S_WR_HOLD: begin
                if (!hold_done_s) begin
                    state_nxt_s = S_WR_HOLD;
                end else if ((cmd_r == CMD_BURST) && (cnt_r > 16'd1)) begin
                    state_nxt_s = S_DATA;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD_ISSUE: state_nxt_s = (!busy_i && !rd_ready_i) ? S_RD_WAIT : S_RD_ISSUE;
            S_RD_WAIT: begin
                if (rd_ready_i || timeout_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RD_WAIT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Request strobes, drop/clear conditions and readback mux
    always_comb begin
        hold_done_s = (hold_cnt_r >= 16'(HOLD_LAST));
        timeout_s   = TMO_EN && (state_r == S_RD_WAIT) && !rd_ready_i &&
                      (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 1));
        wr_pulse_s  = (state_r == S_WR_ISSUE) && !busy_i;
        rd_pulse_s  = (state_r == S_RD_ISSUE) && !busy_i && !rd_ready_i;
        drop_s      = word_valid_i && ((state_r == S_WR_ISSUE) || (state_r == S_WR_HOLD) ||
                                       (state_r == S_RD_ISSUE) || (state_r == S_RD_WAIT));
        clr_flags_s = word_valid_i && (state_r == S_REG_RD) && (reg_addr_r == 8'h01);
        case (reg_addr_r)
            8'h00:   word_s = ID_WORD;
            8'h01:   word_s = {12'b0, tmo_r, ovf_r, busy_i, (state_r != S_IDLE)};
            8'h04:   word_s = {8'b0, mem_dat_r[7:0]};
            8'h05:   word_s = {8'b0, mem_dat_r[15:8]};
            8'h06:   word_s = mem_dat_r;
            8'h08:   word_s = mem_addr_r[15:0];
            8'h09:   word_s = mem_addr_r[31:16];
            default: word_s = 16'h0000;
        endcase
    end

    // Datapath, request outputs and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_r       <= CMD_RD;
            mem_addr_r  <= 32'd0;
            mem_dat_r   <= 16'd0;
            reg_addr_r  <= 8'd0;
            cnt_r       <= 16'd0;
            hold_cnt_r  <= 16'd0;
            tmo_cnt_r   <= 32'd0;
            ovf_r       <= 1'b0;
            tmo_r       <= 1'b0;
            wr_enable_r <= 1'b0;
            rd_enable_r <= 1'b0;
            wr_addr_r   <= 32'd0;
            wr_data_r   <= 16'd0;
            rd_addr_r   <= 32'd0;
        end else begin
            wr_enable_r <= wr_pulse_s;
            rd_enable_r <= rd_pulse_s;
            if (wr_pulse_s) begin
                wr_addr_r <= mem_addr_r;
                wr_data_r <= mem_dat_r;
            end
            if (rd_pulse_s) begin
                rd_addr_r <= mem_addr_r;
            end
            hold_cnt_r <= (state_r == S_WR_HOLD) ? hold_cnt_r + 16'd1 : 16'd0;
            tmo_cnt_r  <= (state_r == S_RD_WAIT) ? tmo_cnt_r + 32'd1 : 32'd0;
            case (state_r)
                S_IDLE: begin
                    if (word_valid_i) begin
                        case (word_i[15:8])
                            8'h80:   reg_addr_r <= word_i[7:0];
                            8'hC0:   cmd_r <= CMD_RD;
                            8'hC1:   cmd_r <= CMD_WR;
                            8'hC2:   cmd_r <= CMD_BURST;
                            default: cmd_r <= cmd_r;
                        endcase
                    end
                end
                S_ADDR_LO: if (word_valid_i) mem_addr_r[15:0]  <= word_i;
                S_ADDR_HI: if (word_valid_i) mem_addr_r[31:16] <= word_i;
                S_CNT:     if (word_valid_i) cnt_r <= word_i;
                S_DATA:    if (word_valid_i) mem_dat_r <= word_i;
                S_WR_HOLD: begin
                    if (hold_done_s && (cmd_r == CMD_BURST) && (cnt_r > 16'd1)) begin
                        mem_addr_r <= mem_addr_r + 32'd1;
                        cnt_r      <= cnt_r - 16'd1;
                    end
                end
                S_RD_WAIT: begin
                    if (rd_ready_i) begin
                        mem_dat_r <= rd_data_i;
                    end else if (timeout_s) begin
                        mem_dat_r <= 16'hDEAD;
                    end
                end
                default: cmd_r <= cmd_r;
            endcase
            // A status read acknowledges both flags; nothing can set them in REG_RD.
            if (clr_flags_s) begin
                ovf_r <= 1'b0;
                tmo_r <= 1'b0;
            end else begin
                if (drop_s)    ovf_r <= 1'b1;
                if (timeout_s) tmo_r <= 1'b1;
            end
        end
    end

    assign word_o      = word_s;
    assign wr_addr_o   = wr_addr_r;
    assign wr_data_o   = wr_data_r;
    assign wr_enable_o = wr_enable_r;
    assign rd_addr_o   = rd_addr_r;
    assign rd_enable_o = rd_enable_r;
    assign ovf_o       = ovf_r;
    assign tmo_o       = tmo_r;

endmodule

// File: tb/tb_spi_sdram_bridge.sv
// Directed self-checking bench for spi_sdram_bridge: register reads, single
// write/read, wrapping burst, overflow flag, optional timeout and async reset.
module tb_spi_sdram_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] word_i;
    logic        word_valid_i;
    logic [15:0] word_o;
    logic [31:0] wr_addr_o;
    logic [15:0] wr_data_o;
    logic        wr_enable_o;
    logic [31:0] rd_addr_o;
    logic        rd_enable_o;
    logic [15:0] rd_data_i;
    logic        rd_ready_i;
    logic        busy_i;
    logic        ovf_o;
    logic        tmo_o;

    int          checks = 0;
    int          errors = 0;
    int          wr_n = 0;
    logic [31:0] log_addr [0:15];
    logic [15:0] log_data [0:15];
    bit          model_en = 1'b1;

    spi_sdram_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_o(word_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_enable_o(wr_enable_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
        .rd_data_i(rd_data_i), .rd_ready_i(rd_ready_i), .busy_i(busy_i),
        .ovf_o(ovf_o), .tmo_o(tmo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        @(negedge clk_i);
        word_i = w;
        word_valid_i = 1'b1;
        @(negedge clk_i);
        word_valid_i = 1'b0;
        word_i = 16'h0000;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (dut.state_r == 4'd0) break;
            @(negedge clk_i);
        end
    endtask

    // Write-pulse logger
    initial begin
        forever begin
            @(negedge clk_i);
            if (wr_enable_o === 1'b1 && wr_n < 16) begin
                log_addr[wr_n] = wr_addr_o;
                log_data[wr_n] = wr_data_o;
                wr_n++;
            end
        end
    end

    // SDRAM read model: data returns 5 cycles after the read request
    initial begin
        rd_ready_i = 1'b0;
        rd_data_i  = 16'h0000;
        forever begin
            @(negedge clk_i);
            if (model_en && rd_enable_o === 1'b1) begin
                repeat (4) @(negedge clk_i);
                rd_data_i  = 16'hA55A;
                rd_ready_i = 1'b1;
                @(negedge clk_i);
                rd_ready_i = 1'b0;
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        word_i = 16'h0000;
        word_valid_i = 1'b0;
        busy_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_wr_en",   {31'd0, wr_enable_o}, 32'd0);
        check("rst_rd_en",   {31'd0, rd_enable_o}, 32'd0);
        check("rst_wr_addr", wr_addr_o, 32'd0);
        check("rst_wr_data", {16'd0, wr_data_o}, 32'd0);
        check("rst_rd_addr", rd_addr_o, 32'd0);
        check("rst_ovf",     {31'd0, ovf_o}, 32'd0);
        check("rst_tmo",     {31'd0, tmo_o}, 32'd0);

        // ID register read
        send(16'h8000);
        check("id_word", {16'd0, word_o}, 32'h5555);
        send(16'h0000);
        check("id_idle", {28'd0, dut.state_r}, 32'd0);

        // Single write: pulse 2 cycles after the data strobe
        wr_n = 0;
        send(16'hC100);
        send(16'h1234);
        send(16'h0000);
        send(16'hBEEF);
        check("wr_not_yet", {31'd0, wr_enable_o}, 32'd0);
        @(negedge clk_i);
        check("wr_pulse", {31'd0, wr_enable_o}, 32'd1);
        check("wr_addr",  wr_addr_o, 32'h0000_1234);
        check("wr_data",  {16'd0, wr_data_o}, 32'h0000_BEEF);
        @(negedge clk_i);
        check("wr_one_cycle", {31'd0, wr_enable_o}, 32'd0);
        wait_idle(20);
        check("wr_count", wr_n, 32'd1);

        // Single read through the model
        send(16'hC000);
        send(16'h0010);
        send(16'h0000);
        for (int i = 0; i < 20; i++) begin
            if (rd_enable_o === 1'b1) break;
            @(negedge clk_i);
        end
        check("rd_pulse", {31'd0, rd_enable_o}, 32'd1);
        check("rd_addr",  rd_addr_o, 32'h0000_0010);
        @(negedge clk_i);
        check("rd_one_cycle", {31'd0, rd_enable_o}, 32'd0);
        wait_idle(40);
        check("rd_idle", {28'd0, dut.state_r}, 32'd0);
        send(16'h8006);
        check("rd_mem_dat", {16'd0, word_o}, 32'h0000_A55A);
        send(16'h0000);
        send(16'h8005);
        check("rd_mem_dat_hi", {16'd0, word_o}, 32'h0000_00A5);
        send(16'h0000);
        send(16'h8004);
        check("rd_mem_dat_lo", {16'd0, word_o}, 32'h0000_005A);
        send(16'h0000);
        send(16'h8008);
        check("mem_addr_lo", {16'd0, word_o}, 32'h0000_0010);
        send(16'h0000);

        // Burst of three with 32-bit address wrap
        wr_n = 0;
        send(16'hC200);
        send(16'hFFFF);
        send(16'hFFFF);
        send(16'h0003);
        send(16'h0001);
        repeat (6) @(negedge clk_i);
        send(16'h0002);
        repeat (6) @(negedge clk_i);
        send(16'h0003);
        repeat (10) @(negedge clk_i);
        check("burst_count", wr_n, 32'd3);
        check("burst_a0", log_addr[0], 32'hFFFF_FFFF);
        check("burst_a1", log_addr[1], 32'h0000_0000);
        check("burst_a2", log_addr[2], 32'h0000_0001);
        check("burst_d0", {16'd0, log_data[0]}, 32'd1);
        check("burst_d1", {16'd0, log_data[1]}, 32'd2);
        check("burst_d2", {16'd0, log_data[2]}, 32'd3);
        check("burst_idle", {28'd0, dut.state_r}, 32'd0);
        check("burst_no_ovf", {31'd0, ovf_o}, 32'd0);

        // Zero count: no writes, following word is an unknown opcode
        send(16'hC200);
        send(16'h0000);
        send(16'h0000);
        send(16'h0000);
        check("cnt0_idle", {28'd0, dut.state_r}, 32'd0);
        send(16'h0202);
        repeat (6) @(negedge clk_i);
        check("cnt0_no_write", wr_n, 32'd3);

        // Overflow: strobe while the write is in progress
        send(16'hC100);
        send(16'h0020);
        send(16'h0000);
        send(16'h1111);
        send(16'h8000);
        check("ovf_set", {31'd0, ovf_o}, 32'd1);
        wait_idle(20);
        check("ovf_wr_addr", wr_addr_o, 32'h0000_0020);
        check("ovf_wr_data", {16'd0, wr_data_o}, 32'h0000_1111);
        send(16'h8001);
        check("status_ovf", {16'd0, word_o}, 32'h0000_0005);
        send(16'h0000);
        check("ovf_cleared", {31'd0, ovf_o}, 32'd0);
        check("status_idle", {28'd0, dut.state_r}, 32'd0);

`ifdef SPI_SDRAM_BRIDGE_TIMEOUT_EN
        // Read with no response
        model_en = 1'b0;
        send(16'hC000);
        send(16'h0040);
        send(16'h0000);
        for (int i = 0; i < 1100; i++) begin
            if (tmo_o === 1'b1) break;
            @(negedge clk_i);
        end
        check("tmo_set", {31'd0, tmo_o}, 32'd1);
        check("tmo_idle", {28'd0, dut.state_r}, 32'd0);
        send(16'h8006);
        check("tmo_dead", {16'd0, word_o}, 32'h0000_DEAD);
        send(16'h0000);
        send(16'h8001);
        check("status_tmo", {16'd0, word_o}, 32'h0000_0009);
        send(16'h0000);
        check("tmo_cleared", {31'd0, tmo_o}, 32'd0);
        model_en = 1'b1;
`endif

        // Reset mid-burst cuts the pulse in flight
        send(16'hC200);
        send(16'h0100);
        send(16'h0000);
        send(16'h000A);
        wr_n = 0;
        send(16'h0001);
        @(posedge clk_i);
        #1;
        check("mid_pulse", {31'd0, wr_enable_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("arst_wr_en",   {31'd0, wr_enable_o}, 32'd0);
        check("arst_wr_addr", wr_addr_o, 32'd0);
        check("arst_wr_data", {16'd0, wr_data_o}, 32'd0);
        check("arst_idle",    {28'd0, dut.state_r}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        send(16'h0002);
        repeat (10) @(negedge clk_i);
        check("arst_no_write", wr_n, 32'd0);
        check("arst_still_idle", {28'd0, dut.state_r}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sdram_bridge.md
# spi_sdram_bridge

Command decoder between the 16-bit SPI slave and the SDRAM controller. It consumes each received SPI word and decodes register reads, single SDRAM reads and writes, and auto-incrementing burst writes. It drives the controller's host-side request port and supplies the word the SPI slave shifts out on the next transfer. It replaces the ad-hoc SPI state machine in the top level.

## Interface
- `WR_HOLD`, default 2: idle cycles after each `wr_enable_o` pulse before the next word is accepted.
- `TIMEOUT_CYCLES`, default 1024: read-wait limit. Used only with `SPI_SDRAM_BRIDGE_TIMEOUT_EN`.
- `ID_WORD`, default 16'h5555: value returned by register 0x00.

Ports:
- `clk_i`  in  1: single clock. The SPI host side and SDRAM host side are both synchronous to it.
- `rst_i`  in  1: asynchronous, active-high reset.
- `word_i`  in  16: received SPI word.
- `word_valid_i`  in  1: one-cycle strobe; `word_i` is valid in that cycle.
- `word_o`  out  16: word for the next SPI transmit.
- `wr_addr_o`  out  32: SDRAM write address.
- `wr_data_o`  out  16: SDRAM write data.
- `wr_enable_o`  out  1: SDRAM write request pulse.
- `rd_addr_o`  out  32: SDRAM read address.
- `rd_enable_o`  out  1: SDRAM read request pulse.
- `rd_data_i`  in  16: SDRAM read data.
- `rd_ready_i`  in  1: SDRAM read data valid.
- `busy_i`  in  1: SDRAM controller busy.
- `ovf_o`  out  1: sticky flag; a word was dropped.
- `tmo_o`  out  1: sticky flag; a read timed out.

## Operation
- Opcode is `word_i[15:8]` in IDLE. Unknown opcodes are ignored and the block stays in IDLE.
- **0x80, register read:** latch `reg_addr = word_i[7:0]`, go to REG_RD. The next strobe returns to IDLE; its data is ignored.
  - If `reg_addr` was 0x01, that strobe clears `ovf_o` and `tmo_o`.
- **0xC0, memory read:** ADDR_LO → ADDR_HI → RD_ISSUE.
- **0xC1, memory write:** ADDR_LO → ADDR_HI → DATA → WR_ISSUE.
- **0xC2, burst write:** ADDR_LO → ADDR_HI → CNT → DATA → WR_ISSUE, repeated for each word.
  - ADDR_LO and ADDR_HI load `mem_addr[15:0]` and `mem_addr[31:16]`.
  - CNT loads the 16-bit count `n`. If `n == 0`, return to IDLE with no writes.
- **DATA:** a strobe latches `mem_dat = word_i`, go to WR_ISSUE.
- **WR_ISSUE:** when `busy_i` is low, pulse `wr_enable_o` with `wr_addr_o = mem_addr` and `wr_data_o = mem_dat`, then go to WR_HOLD.
- **WR_HOLD:** counts `WR_HOLD` cycles. Then:
  - if burst and remaining count > 1: `mem_addr <= mem_addr + 1` (32-bit wrap, 0xFFFFFFFF → 0), decrement count, go to DATA;
  - otherwise go to IDLE.
- **RD_ISSUE:** when `busy_i` is low and `rd_ready_i` is low, pulse `rd_enable_o` with `rd_addr_o = mem_addr`, then go to RD_WAIT.
- **RD_WAIT:** on `rd_ready_i`, capture `mem_dat = rd_data_i`, go to IDLE.
- Any strobe during WR_ISSUE, WR_HOLD, RD_ISSUE or RD_WAIT is dropped and sets `ovf_o`. The state is unaffected.
- `word_o` is combinational from `reg_addr`:
  - 0x00: `ID_WORD`
  - 0x01: {12'b0, `tmo_o`, `ovf_o`, `busy_i`, state != IDLE}
  - 0x04: {8'b0, `mem_dat[7:0]`}
  - 0x05: {8'b0, `mem_dat[15:8]`}
  - 0x06: `mem_dat`
  - 0x08: `mem_addr[15:0]`
  - 0x09: `mem_addr[31:16]`
  - all others: 0.

## Timing
- **Reset:** all outputs, `mem_addr`, `mem_dat`, `reg_addr`, the count and the flags go to 0. The state goes to IDLE immediately, including mid-burst or mid-read.
  - A request pulse in flight is cut short.
  - No pulse is emitted after reset deassertion until a new command completes.
- **Strobe:** a strobe at edge T changes state at T+1.
- **Write pulse:** `wr_enable_o` rises at the first edge where the state is WR_ISSUE and `busy_i` is low. It is high for exactly one cycle. Address and data are stable from that edge until the next write.
  - Minimum DATA-strobe-to-`wr_enable_o` latency is 2 cycles.
- **Read pulse:** `rd_enable_o` is exactly one cycle.
  - `mem_dat` is updated on the edge after `rd_ready_i` is sampled high.
  - `rd_ready_i` high in RD_ISSUE blocks the issue until it falls.
- **Simultaneous events:** a strobe in the same cycle as `rd_ready_i` in RD_WAIT is dropped and sets `ovf_o`; the capture still occurs.
- **Burst pacing:** the minimum spacing between data words is 2 + `WR_HOLD` cycles plus any `busy_i` stall.

## Configuration
- `SPI_SDRAM_BRIDGE_TIMEOUT_EN` defined: a counter runs in RD_WAIT.
  - After `TIMEOUT_CYCLES` cycles without `rd_ready_i`: set `tmo_o`, load `mem_dat = 16'hDEAD`, go to IDLE.
  - The counter is cleared on entry to RD_WAIT.
- Undefined: RD_WAIT waits indefinitely and `tmo_o` is tied to 0.

## Test plan
- Strobe 0x8000, then 0x0000 → `word_o` = 0x5555 after the first strobe; state IDLE after the second.
- 0xC100, 0x1234, 0x0000, 0xBEEF with `busy_i` = 0 → one `wr_enable_o` pulse with `wr_addr_o` = 0x00001234 and `wr_data_o` = 0xBEEF, 2 cycles after the last strobe.
- 0xC000, 0x0010, 0x0000; model returns 0xA55A 5 cycles after `rd_enable_o`; then 0x8006, 0 → `rd_addr_o` = 0x10; `word_o` = 0xA55A.
- 0xC200, 0xFFFF, 0xFFFF, 0x0003, then data 1, 2, 3 paced at 8 cycles → three writes to addresses 0xFFFFFFFF, 0x0, 0x1; count 0 → no write.
- Strobe during WR_HOLD → `ovf_o` = 1; reading register 0x01 returns bit 2 set, then the flag clears. With `SPI_SDRAM_BRIDGE_TIMEOUT_EN` and no `rd_ready_i` → `tmo_o` = 1 after 1024 cycles and `mem_dat` = 0xDEAD.
- Assert `rst_i` mid-burst → state IDLE, all outputs 0 asynchronously, no further write pulses.
